// File: rtl/update_monitor_ctrl.sv
// update_monitor_ctrl: walks the monitor position ROM and repaints each
// monitor bit as an ASCII '0'/'1' character on the VGA text screen.
// A shadow of the last painted bits lets a scan skip unchanged characters.
// The scan sequence is LOOKUP -> WRITE -> ADVANCE for each entry. An entry
// that is already on screen goes LOOKUP -> ADVANCE.
//
// Handshake (wr_req / wr_ack): wr_req rises together with a stable
// {wr_col, wr_row, wr_char} payload. The payload and wr_req are held until the
// first cycle in which wr_ack is high, and that cycle completes the transfer.
// wr_req drops in the following cycle. wr_ack is ignored while wr_req is low.
module update_monitor_ctrl #(
    parameter int NUM_ENTRIES = 82,
    parameter int ADDR_W      = 10,
    parameter int COL_W       = 7,
    parameter int ROW_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   force_all,
    input  logic [NUM_ENTRIES-1:0] mon_bits,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [31:0]            rom_data,
    output logic                   wr_req,
    output logic [COL_W-1:0]       wr_col,
    output logic [ROW_W-1:0]       wr_row,
    output logic [7:0]             wr_char,
    input  logic                   wr_ack,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_WRITE   = 2'd2,
        S_ADVANCE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [IDX_W-1:0]       r_idx;
    logic [NUM_ENTRIES-1:0] r_snap;
    logic [NUM_ENTRIES-1:0] r_shadow;
    logic                   r_shadow_valid;
    logic                   r_force;
    logic                   r_pending;
    logic                   r_pending_force;
    logic                   r_done;
    logic [COL_W-1:0]       r_wr_col;
    logic [ROW_W-1:0]       r_wr_row;
    logic [7:0]             r_wr_char;

    logic                   w_kick;
    logic                   w_need;
    logic                   w_last;
    logic                   w_unused_rom;

    // Only the position field {col, row} = rom_data[17:7] is meaningful.
    assign w_unused_rom = ^{rom_data[31:18], rom_data[6:0]};

    // A scan is launched by a fresh start or by one queued while busy.
    assign w_kick = start | r_pending;

    // Repaint when forced, when the screen content is unknown, or on a change.
    assign w_need = r_force | ~r_shadow_valid | (r_snap[r_idx] ^ r_shadow[r_idx]);
    assign w_last = (r_idx == IDX_W'(NUM_ENTRIES - 1));

    assign rom_addr = ADDR_W'(r_idx);
    assign wr_col   = r_wr_col;
    assign wr_row   = r_wr_row;
    assign wr_char  = r_wr_char;
    assign done     = r_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_kick) w_next_state = S_LOOKUP;
            S_LOOKUP:  w_next_state = w_need ? S_WRITE : S_ADVANCE;
            S_WRITE:   if (wr_ack) w_next_state = S_ADVANCE;
            S_ADVANCE: w_next_state = w_last ? S_IDLE : S_LOOKUP;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Output decode from state. This drives wr_req low as soon as reset is applied.
    always_comb begin
        busy      = (r_state != S_IDLE);
        wr_req    = (r_state == S_WRITE);
        dbg_state = r_state;
    end

    // Scan datapath: snapshot, index walk, write payload, shadow and pending start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx           <= '0;
            r_snap          <= '0;
            r_shadow        <= '0;
            r_shadow_valid  <= 1'b0;
            r_force         <= 1'b0;
            r_pending       <= 1'b0;
            r_pending_force <= 1'b0;
            r_done          <= 1'b0;
            r_wr_col        <= '0;
            r_wr_row        <= '0;
            r_wr_char       <= '0;
        end else begin
            r_done <= 1'b0;
            // A start that arrives mid-scan is remembered and runs afterwards.
            if (start && (r_state != S_IDLE)) begin
                r_pending       <= 1'b1;
                r_pending_force <= r_pending_force | force_all;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_kick) begin
                        r_snap          <= mon_bits;
                        r_force         <= (start & force_all) | r_pending_force;
                        r_pending       <= 1'b0;
                        r_pending_force <= 1'b0;
                        r_idx           <= '0;
                    end
                end
                S_LOOKUP: begin
                    r_wr_col  <= rom_data[17:17-COL_W+1];
                    r_wr_row  <= rom_data[ROW_W+6:7];
                    r_wr_char <= r_snap[r_idx] ? 8'h31 : 8'h30;
                end
                S_WRITE: begin
                    if (wr_ack) begin
                        r_shadow[r_idx] <= r_snap[r_idx];
                    end
                end
                S_ADVANCE: begin
                    if (w_last) begin
                        r_shadow_valid <= 1'b1;
                        r_done         <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_update_monitor_ctrl.sv
// Bench for update_monitor_ctrl: random ROM contents and monitor bits. A
// shadow/queue reference model supplies the expected writes and the expected
// done cycle.
module tb_update_monitor_ctrl;

  localparam int N = 82;
  localparam int W = 26;  // {idx[6:0], col[6:0], row[3:0], char[7:0]}

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          force_all = 1'b0;
  logic [N-1:0]  mon_bits = '0;
  logic [9:0]    rom_addr;
  logic [31:0]   rom_data;
  logic          wr_req;
  logic [6:0]    wr_col;
  logic [3:0]    wr_row;
  logic [7:0]    wr_char;
  logic          wr_ack = 1'b1;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  logic [31:0]   rom_mem [0:N-1];
  logic [W-1:0]  exp_q[$];
  logic [N-1:0]  m_shadow = '0;
  bit            m_valid = 1'b0;

  int n_total = 0;
  int n_pass = 0;
  int stall_cnt = 0;
  int stall_seen = 0;
  int writes_seen = 0;

  update_monitor_ctrl #(.NUM_ENTRIES(N), .ADDR_W(10), .COL_W(7), .ROW_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .force_all(force_all),
    .mon_bits(mon_bits), .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_req(wr_req), .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char),
    .wr_ack(wr_ack), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // combinational ROM
  assign rom_data = (rom_addr < 10'd82) ? rom_mem[rom_addr[6:0]] : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // reference model: one scan from the update rules
  task automatic model_scan(input logic [N-1:0] snap, input bit frc, output int nw);
    nw = 0;
    for (int i = 0; i < N; i++) begin
      if (frc || !m_valid || (snap[i] != m_shadow[i])) begin
        exp_q.push_back({7'(i), rom_mem[i][17:11], rom_mem[i][10:7],
                         (snap[i] ? 8'h31 : 8'h30)});
        nw++;
      end
      m_shadow[i] = snap[i];
    end
    m_valid = 1'b1;
  endtask

  // ack driver: stalls the first stall_cnt WRITE cycles, otherwise acks
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && wr_req && stall_cnt > 0) begin
      wr_ack = 1'b0;
      stall_cnt--;
    end else begin
      wr_ack = 1'b1;
    end
  end

  // write monitor / scoreboard
  initial begin
    logic [W-1:0]  exp_w;
    logic [18:0]   held;
    bit            held_valid;
    held_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_valid = 1'b0;
      end else if (wr_req) begin
        if (held_valid) check("hold_stable", 32'({wr_col, wr_row, wr_char}), 32'(held));
        if (wr_ack) begin
          writes_seen++;
          check("write_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check("write_content", 32'({rom_addr[6:0], wr_col, wr_row, wr_char}), 32'(exp_w));
          end
          held_valid = 1'b0;
        end else begin
          held = {wr_col, wr_row, wr_char};
          held_valid = 1'b1;
          stall_seen++;
        end
      end else begin
        if (held_valid) check("req_held", 32'(wr_req), 32'd1);
        held_valid = 1'b0;
      end
    end
  end

  // Called at the negedge of cycle 1 of a scan. Returns the cycle in which done is seen.
  task automatic wait_done(input int inject_at, input int toggle_at, input int limit,
                           output int dc, output int gaps);
    int n;
    n = 1;
    dc = -1;
    gaps = 0;
    while (n <= limit) begin
      if (done) begin
        dc = n;
        break;
      end
      if (!busy) gaps++;
      if (n == inject_at) begin
        start = 1'b1;
        force_all = 1'b1;
      end else begin
        start = 1'b0;
        force_all = 1'b0;
      end
      if (n == toggle_at) mon_bits[N-1] = ~mon_bits[N-1];
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_scan(input string tag, input bit frc, input int stall_cycles, input int toggle_at);
    int nw, dc, gaps;
    model_scan(mon_bits, frc, nw);
    stall_cnt = stall_cycles;
    stall_seen = 0;
    writes_seen = 0;
    start = 1'b1;
    force_all = frc;
    @(negedge clk);
    start = 1'b0;
    force_all = 1'b0;
    wait_done(0, toggle_at, 1000, dc, gaps);
    check({tag, "_done_cycle"}, 32'(dc), 32'(1 + 2 * N + nw + stall_cycles));
    check({tag, "_busy_gaps"}, 32'(gaps), 32'd0);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_write_count"}, 32'(writes_seen), 32'(nw));
    check({tag, "_stall_cycles"}, 32'(stall_seen), 32'(stall_cycles));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int nw, dc, gaps;
    bit found;
    for (int i = 0; i < N; i++) rom_mem[i] = $urandom;
    rom_mem[5] = 32'h0;
    rom_mem[60] = 32'h0;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_wr_pos", 32'({wr_col, wr_row}), 32'd0);
    check("rst_wr_char", 32'(wr_char), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // cold scan: every entry painted '0'
    mon_bits = '0;
    do_scan("cold", 1'b0, 0, 0);

    // incremental: two changed bits
    mon_bits[3] = 1'b1;
    mon_bits[40] = 1'b1;
    do_scan("incr", 1'b0, 0, 0);

    // back-pressure on the first write
    mon_bits[0] = ~mon_bits[0];
    mon_bits[10] = ~mon_bits[10];
    do_scan("bp", 1'b0, 5, 0);

    // random sparse changes
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) mon_bits[i] = ~mon_bits[i];
      do_scan("rand", 1'b0, $urandom_range(0, 3), 0);
    end

    // start in the same cycle as done begins the next scan at once
    mon_bits[20] = ~mon_bits[20];
    model_scan(mon_bits, 1'b0, nw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, 0, 1000, dc, gaps);
    check("coinc_first_done", 32'(dc), 32'(1 + 2 * N + nw));
    model_scan(mon_bits, 1'b0, nw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("coinc_busy_next", 32'(busy), 32'd1);
    wait_done(0, 0, 1000, dc, gaps);
    check("coinc_second_done", 32'(dc), 32'(1 + 2 * N + nw));
    check("coinc_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // forced start during a no-change scan is queued, then rewrites everything
    model_scan(mon_bits, 1'b0, nw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(50, 0, 1000, dc, gaps);
    check("pend_first_done", 32'(dc), 32'(1 + 2 * N + nw));
    check("pend_busy_at_done", 32'(busy), 32'd0);
    writes_seen = 0;
    model_scan(mon_bits, 1'b1, nw);
    @(negedge clk);
    check("pend_restart_busy", 32'(busy), 32'd1);
    check("pend_restart_done", 32'(done), 32'd0);
    wait_done(0, 0, 1000, dc, gaps);
    check("pend_second_done", 32'(dc), 32'(1 + 3 * N));
    check("pend_write_count", 32'(writes_seen), 32'(N));
    check("pend_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // reset while writing entry 20
    model_scan(mon_bits, 1'b1, nw);
    start = 1'b1;
    force_all = 1'b1;
    @(negedge clk);
    start = 1'b0;
    force_all = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (wr_req && rom_addr == 10'd20) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstmid_reached_20", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_wr_req", 32'(wr_req), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    exp_q.delete();
    m_valid = 1'b0;
    m_shadow = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_scan("after_rst", 1'b0, 0, 0);

    // mon_bits change mid-scan is not seen until the next scan
    do_scan("snap", 1'b0, 0, 10);
    do_scan("snap_next", 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/update_monitor_ctrl.md
Name: update_monitor_ctrl

Overview:
- Sequencer that repaints the CPU monitor fields (PC, ALU, register-file and RAM signals) on the VGA character screen, one bit per character.
- Walks the monitor position ROM over entries 0..NUM_ENTRIES-1 and takes each entry's screen position from the ROM.
- Writes ASCII '0' or '1' for the matching monitor bit into the VGA character buffer through a request/acknowledge port.
- Keeps a shadow copy of the last painted bits and skips unchanged characters, except on the first scan after reset or a forced scan.

Parameters:
- NUM_ENTRIES, 82, number of monitor entries, mapped to ROM addresses 0..81.
- ADDR_W, 10, ROM address width.
- COL_W, 7, screen column width.
- ROW_W, 4, screen row width. COL_W+ROW_W must equal 11.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request to scan the monitor fields.
- force_all  in  1  sampled together with start; when high, every entry is rewritten.
- mon_bits  in  NUM_ENTRIES  monitor bit vector; bit i belongs to ROM entry i.
- rom_addr  out  ADDR_W  address to the monitor position ROM.
- rom_data  in  32  ROM word; position is rom_data[17:7] = {col, row}.
- wr_req  out  1  character write request.
- wr_col  out  COL_W  column of the character to write.
- wr_row  out  ROW_W  row of the character to write.
- wr_char  out  8  character code to write.
- wr_ack  in  1  character buffer has accepted the write.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset values: all outputs 0, idx=0, shadow=0, shadow_valid=0, pending=0, state=IDLE.
- rom_addr = zero-extended idx, registered. The ROM is combinational, so rom_data is valid in the same cycle.
- IDLE:
  - On start, or on pending set: snap<=mon_bits; force_r<=force_all|pending_force; clear pending and pending_force; idx<=0; go to LOOKUP.
- LOOKUP (1 cycle):
  - Latch wr_col<=rom_data[17:17-COL_W+1] and wr_row<=rom_data[ROW_W+6:7].
  - Latch wr_char<= 8'h31 if snap[idx] is 1, else 8'h30.
  - need = force_r | ~shadow_valid | (snap[idx]^shadow[idx]).
  - If need, go to WRITE; otherwise go to ADVANCE.
- WRITE (1 cycle minimum):
  - wr_req=1 throughout; wr_col, wr_row and wr_char stay stable until acknowledged.
  - On a cycle with wr_ack=1: shadow[idx]<=snap[idx]; go to ADVANCE; wr_req drops in the next cycle.
  - No timeout; the block waits indefinitely.
  - wr_ack outside WRITE is ignored.
- ADVANCE (1 cycle):
  - If idx==NUM_ENTRIES-1: shadow_valid<=1; done<=1 for the next cycle; go to IDLE.
  - Otherwise idx<=idx+1; go to LOOKUP.
- Cycle counts, counted from the clock edge that samples start:
  - With zero-wait acks, entry k occupies cycles 3k+1..3k+3, so a full write scan raises done and drops busy in cycle 3*NUM_ENTRIES+1 (247).
  - A skipped entry takes 2 cycles, so a scan with no changes raises done in cycle 2*NUM_ENTRIES+1 (165).
- start while busy:
  - Not dropped. Sets pending, and pending_force |= force_all.
  - A new scan begins in the cycle after done; it snapshots mon_bits afresh.
- mon_bits changes mid-scan have no effect on the current scan, which uses snap.
- start in the same cycle that done is high (state IDLE) starts a scan immediately.
- Reset asserted mid-scan:
  - All state clears immediately and wr_req drops asynchronously.
  - shadow_valid=0, so the next scan repaints every entry.
- Entries whose ROM word is 0 are written to position (0,0) like any other entry; no special case.

Test Plan:
- Cold scan: after reset, pulse start with mon_bits=0 and tie wr_ack=1 -> 82 writes of 8'h30, in ROM order, at the ROM positions. done is high in cycle 247 only, and busy is low from cycle 247.
- Incremental scan: then set mon_bits bit 3 =1 and bit 40 =1, pulse start -> exactly 2 writes (idx 3 and idx 40, char 8'h31); done in cycle 165+2=167.
- Back-pressure: hold wr_ack low for 5 cycles on the first write -> wr_req, wr_col, wr_row and wr_char stay stable for 6 cycles; the write completes on ack and total latency grows by 5.
- start during scan: pulse start with force_all=1 at cycle 50 of a scan -> after done, a second scan starts in the next cycle and rewrites all 82 entries.
- Reset mid-WRITE: assert rst_n=0 at entry 20 -> wr_req, busy and done are 0 immediately. The next start repaints all 82 entries, even though mon_bits is unchanged.
- Snapshot: toggle mon_bits bit 81 at cycle 10 of a no-change scan -> no write for entry 81 in that scan; the next start writes entry 81.
